// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Byte-addressed load/store front end for a word-organised data_mem that has
// no byte enables. A core request (byte address, RISC-V funct3, store data) is
// turned into word-indexed data_mem accesses:
//   - loads read the word, pick the byte/half lane and sign/zero extend it;
//   - SW writes the word directly;
//   - SB/SH read the word, merge the new lane in, then write it back;
//   - misaligned or illegal requests respond with resp_err and never touch
//     memory.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while IDLE)
//   req_we                1 = store, 0 = load
//   req_funct3            000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr              byte address (wraps modulo DEPTH*4)
//   req_wdata             store data, low byte/half used for SB/SH
//   resp_valid            one-cycle completion pulse
//   resp_rdata            extended load data, 0 for stores and errors
//   resp_err              misaligned / illegal funct3, valid with resp_valid
//   mem_write             data_mem write strobe
//   mem_addr              data_mem word address
//   mem_wdata             data_mem write data
//   mem_rdata             data_mem read data, combinational from mem_addr
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     resp_valid,
  output logic [WIDTH-1:0]         resp_rdata,
  output logic                     resp_err,
  output logic                     mem_write,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t state_q, state_d;

  // Captured request. Only the byte-address bits that reach data_mem are kept.
  logic [AW+1:0]    addr_q;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] merge_q;

  logic             accept;
  logic             req_illegal;
  logic             f3_bad;
  logic             misaligned;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] merged;

  // Address bits above the data_mem range are deliberately dropped (wrap).
  logic addr_hi_unused;
  assign addr_hi_unused = ^req_addr[31:AW+2];

  assign accept = req_valid && req_ready;

  // Legality of the incoming request, judged on the raw inputs at accept time.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    f3_bad     = 1'b0;
    misaligned = 1'b0;
    if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11) f3_bad = 1'b1;
    if (req_we && req_funct3[2])                          f3_bad = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_addr[0])          misaligned = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) misaligned = 1'b1;
    req_illegal = f3_bad || misaligned;
  end

  // Lane extraction for loads and lane merge for sub-word stores, both keyed
  // by the captured address and reading the word currently on mem_rdata.
  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];

    case (funct3_q)
      F3_B:    load_val = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_BU:   load_val = {{(WIDTH-8){1'b0}}, byte_sel};
      F3_H:    load_val = {{(WIDTH-16){half_sel[15]}}, half_sel};
      F3_HU:   load_val = {{(WIDTH-16){1'b0}}, half_sel};
      default: load_val = mem_rdata;
    endcase

    merged = mem_rdata;
    if (funct3_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else                        merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && !req_illegal)
          state_d = (req_we && req_funct3 == F3_W) ? WRITE : READ;
      end
      READ:    state_d = we_q ? WRITE : IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state. The write strobe is masked by reset so a
  // reset landing in WRITE can never corrupt memory.
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_write = (state_q == WRITE) && reset_n;
    mem_addr  = (state_q == IDLE) ? '0 : addr_q[AW+1:2];
    mem_wdata = (funct3_q == F3_W) ? wdata_q : merge_q;
  end

  // Request capture, merge register and registered response.
  always_ff @(posedge clk) begin
    // NOTE: these are plain flops, not memory, so all of them are reset; this
    // keeps a dropped request from leaking into the next one.
    if (!reset_n) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q   <= req_addr[AW+1:0];
            we_q     <= req_we;
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            if (req_illegal) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end
          end
        end
        READ: begin
          if (we_q) begin
            merge_q <= merged;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= load_val;
          end
        end
        WRITE: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
